// File: rtl/if_fetch_unit_if.sv
// Fetch-unit bundle: PC handshake, instruction-memory read channels, IF/ID handoff.
// master: the fetch unit (drives requests, pc_write and the instruction outputs).
// slave : the surroundings (PC register, instruction memory, IF/ID register).
interface if_fetch_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // program counter side
    logic [ADDR_W-1:0] pc_in;
    logic              pc_write;
    logic              flush;
    // instruction memory read address channel
    logic              im_ar_valid;
    logic              im_ar_ready;
    logic [ADDR_W-1:0] im_ar_addr;
    // instruction memory read data channel
    logic              im_r_valid;
    logic              im_r_ready;
    logic [DATA_W-1:0] im_r_data;
    logic [1:0]        im_r_resp;
    // IF/ID boundary
    logic              inst_valid;
    logic              inst_ready;
    logic [DATA_W-1:0] inst_out;
    logic [ADDR_W-1:0] inst_pc;
    logic              inst_fault;

    modport master (
        input  pc_in, flush, im_ar_ready, im_r_valid, im_r_data, im_r_resp, inst_ready,
        output pc_write, im_ar_valid, im_ar_addr, im_r_ready, inst_valid, inst_out,
               inst_pc, inst_fault
    );

    modport slave (
        output pc_in, flush, im_ar_ready, im_r_valid, im_r_data, im_r_resp, inst_ready,
        input  pc_write, im_ar_valid, im_ar_addr, im_r_ready, inst_valid, inst_out,
               inst_pc, inst_fault
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Purpose: IF-stage fetch requester; one outstanding single-beat read to instruction memory.
// Latency: pc_in sampled in IDLE -> instruction presented 3 cycles later (1 instr / 4 cycles peak).
// Backpressure: im_ar_valid held until im_ar_ready; instruction held in HOLD until inst_ready.
//
// Ports: clk, rst_n (synchronous, active-low) and bus (if_fetch_unit_if.master) carrying
// pc_in/pc_write/flush, the im_ar_* / im_r_* memory channels and the inst_* IF/ID outputs.
module if_fetch_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    if_fetch_unit_if.master      bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_WAIT = 3'd2,
        S_HOLD = 3'd3,
        S_DROP = 3'd4
    } state_t;

    state_t            state;
    // Set when a flush hit while the request was still waiting for acceptance:
    // the request cannot be withdrawn, so its response must be swallowed later.
    logic              kill;
    logic [ADDR_W-1:0] ar_addr_q;
    logic [DATA_W-1:0] inst_q;
    logic [ADDR_W-1:0] inst_pc_q;
    logic              fault_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            kill      <= 1'b0;
            ar_addr_q <= '0;
            inst_q    <= '0;
            inst_pc_q <= '0;
            fault_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    // A flush here means pc_in is being redirected this edge;
                    // wait one cycle and sample the new value instead.
                    if (!bus.flush) begin
                        ar_addr_q <= bus.pc_in;
                        state     <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (bus.im_ar_ready) begin
                        state <= (bus.flush || kill) ? S_DROP : S_WAIT;
                    end else if (bus.flush) begin
                        kill <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (bus.flush) begin
                        // Data arriving in the flush cycle is simply not captured.
                        state <= bus.im_r_valid ? S_IDLE : S_DROP;
                    end else if (bus.im_r_valid) begin
                        inst_q    <= bus.im_r_data;
                        inst_pc_q <= ar_addr_q;
                        fault_q   <= (bus.im_r_resp != 2'b00);
                        state     <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (bus.flush || bus.inst_ready) begin
                        state <= S_IDLE;
                    end
                end
                S_DROP: begin
                    if (bus.im_r_valid) begin
                        kill  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Handshake outputs are pure state decodes so they never glitch on inputs.
    assign bus.im_ar_valid = (state == S_ADDR);
    assign bus.im_r_ready  = (state == S_WAIT) || (state == S_DROP);
    assign bus.inst_valid  = (state == S_HOLD);
    assign bus.im_ar_addr  = ar_addr_q;
    assign bus.inst_out    = inst_q;
    assign bus.inst_pc     = inst_pc_q;
    assign bus.inst_fault  = fault_q;

    // Every flush redirects the PC; otherwise the PC advances once the
    // instruction is handed to IF/ID. Flush+ready is still a single pulse.
    assign bus.pc_write = bus.flush || ((state == S_HOLD) && bus.inst_ready);

endmodule
